acca_pipe_mul: RTL

ACCA_PIPE_MUL -- requirements
Module: acca_pipe_mul

---
 rtl/acca_pkg.sv | 21 ++
 rtl/acca_pipe_mul_if.sv | 31 +++
 rtl/acca_sub_mul.sv | 21 ++
 rtl/acca_pipe_mul.sv | 131 +++++++++++++
 4 files changed

// File: rtl/acca_pkg.sv
// Shared constants for the approximate pipelined multiplier: quadrant
// bit positions in the mode word and default geometry.
package acca_pkg;

   localparam int MODE_HH = 3;
   localparam int MODE_HL = 2;
   localparam int MODE_LH = 1;
   localparam int MODE_LL = 0;

   localparam int DEF_HW = 4;
   localparam int DEF_K  = 2;

   // Quadrant index: bit1 selects the half of a, bit0 the half of b.
   typedef enum logic [1:0] {
      Q_LL = 2'(MODE_LL),
      Q_LH = 2'(MODE_LH),
      Q_HL = 2'(MODE_HL),
      Q_HH = 2'(MODE_HH)
   } quad_e;

endpackage

// File: rtl/acca_pipe_mul_if.sv
// Operand/result stream bundle for acca_pipe_mul; slave is the multiplier,
// master is whoever feeds operands and consumes results.
interface acca_pipe_mul_if
   import acca_pkg::*;
#(
   parameter int HW = DEF_HW
);
   localparam int W = 2 * HW;

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [3:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   prod;
   logic [2*W-1:0]   err;
   logic [15:0]      done_cnt;

   modport master (
      output in_valid, a, b, mode, out_ready,
      input  in_ready, out_valid, prod, err, done_cnt
   );

   modport slave (
      input  in_valid, a, b, mode, out_ready,
      output in_ready, out_valid, prod, err, done_cnt
   );

endinterface

// File: rtl/acca_sub_mul.sv
// HW x HW unsigned multiplier whose low K product bits are cleared when
// approx is set; purely combinational.
module acca_sub_mul
   import acca_pkg::*;
#(
   parameter int HW = DEF_HW,
   parameter int K  = DEF_K
) (
   input  logic [HW-1:0]   x,
   input  logic [HW-1:0]   y,
   input  logic            approx,
   output logic [2*HW-1:0] p
);
   localparam logic [2*HW-1:0] KEEP_MASK = {(2*HW){1'b1}} << K;

   logic [2*HW-1:0] exact;

   assign exact = (2*HW)'(x) * (2*HW)'(y);
   assign p     = approx ? (exact & KEEP_MASK) : exact;

endmodule

// File: rtl/acca_pipe_mul.sv
// Three-stage approximate multiplier: S1 operands, S2 quadrant sub-products
// plus exact product, S3 prod/err. One shared enable stalls the whole pipe.
module acca_pipe_mul
   import acca_pkg::*;
#(
   parameter int HW = DEF_HW,
   parameter int K  = DEF_K
) (
   input  logic           clk,
   input  logic           rst_n,
   acca_pipe_mul_if.slave bus
);
   localparam int W  = 2 * HW;
   localparam int PW = 2 * HW;
   localparam int RW = 2 * W;

   logic              en;
   logic              fire_out;

   logic              s1_valid_reg;
   logic [W-1:0]      s1_a_reg;
   logic [W-1:0]      s1_b_reg;
   logic [3:0]        s1_mode_reg;

   logic [HW-1:0]     a_half [2];
   logic [HW-1:0]     b_half [2];
   logic [PW-1:0]     sub_p  [4];
   logic [RW-1:0]     exact_next;

   logic              s2_valid_reg;
   logic [PW-1:0]     s2_sub_reg [4];
   logic [RW-1:0]     s2_exact_reg;

   logic [RW-1:0]     prod_next;
   logic [RW-1:0]     err_next;

   logic              s3_valid_reg;
   logic [RW-1:0]     prod_reg;
   logic [RW-1:0]     err_reg;
   logic [15:0]       done_cnt_reg;

   // The pipe only moves when the output slot is empty or being drained.
   assign en       = !s3_valid_reg || bus.out_ready;
   assign fire_out = s3_valid_reg && bus.out_ready;

   assign bus.in_ready  = en;
   assign bus.out_valid = s3_valid_reg;
   assign bus.prod      = prod_reg;
   assign bus.err       = err_reg;
   assign bus.done_cnt  = done_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_a_reg     <= '0;
         s1_b_reg     <= '0;
         s1_mode_reg  <= '0;
      end else if (en) begin
         s1_valid_reg <= bus.in_valid;
         s1_a_reg     <= bus.a;
         s1_b_reg     <= bus.b;
         s1_mode_reg  <= bus.mode;
      end
   end

   assign a_half[0] = s1_a_reg[HW-1:0];
   assign a_half[1] = s1_a_reg[W-1:HW];
   assign b_half[0] = s1_b_reg[HW-1:0];
   assign b_half[1] = s1_b_reg[W-1:HW];

   // Quadrant gi takes the a-half chosen by gi[1] and the b-half by gi[0].
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_quad
         acca_sub_mul #(
            .HW (HW),
            .K  (K)
         ) u_sub (
            .x      (a_half[gi / 2]),
            .y      (b_half[gi % 2]),
            .approx (s1_mode_reg[gi]),
            .p      (sub_p[gi])
         );
      end
   endgenerate

   assign exact_next = RW'(s1_a_reg) * RW'(s1_b_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_reg <= 1'b0;
         s2_exact_reg <= '0;
         for (int i = 0; i < 4; i++) begin
            s2_sub_reg[i] <= '0;
         end
      end else if (en) begin
         s2_valid_reg <= s1_valid_reg;
         s2_exact_reg <= exact_next;
         for (int i = 0; i < 4; i++) begin
            s2_sub_reg[i] <= sub_p[i];
         end
      end
   end

   assign prod_next = (RW'(s2_sub_reg[MODE_HH]) << W)
                    + (RW'(s2_sub_reg[MODE_HL]) << HW)
                    + (RW'(s2_sub_reg[MODE_LH]) << HW)
                    +  RW'(s2_sub_reg[MODE_LL]);
   assign err_next  = s2_exact_reg - prod_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_valid_reg <= 1'b0;
         prod_reg     <= '0;
         err_reg      <= '0;
      end else if (en) begin
         s3_valid_reg <= s2_valid_reg;
         prod_reg     <= prod_next;
         err_reg      <= err_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_cnt_reg <= '0;
      end else if (fire_out && (done_cnt_reg != 16'hFFFF)) begin
         done_cnt_reg <= done_cnt_reg + 16'd1;
      end
   end

endmodule
